ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. Sends one command or data byte to the keyboard, e.g. 0xED (set LEDs) followed by its LED mask.
- Runs the full host request: clock inhibit, start bit, then shifts bits on device-generated clock edges, then checks the device ack bit.
- Drives the PS/2 clock and data lines as open-drain enables. Sits beside the scancode receive path and shares the same line pads.

---
 rtl/ps2_host_tx_pkg.sv | 43 ++++
 rtl/ps2_host_tx_sync_negedge.sv | 42 ++++
 rtl/ps2_host_tx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
//   Shared definitions for the PS/2 host-to-device transmit path:
//   FSM state encoding, frame/bit-count constants, well-known command and
//   response bytes, error codes and the odd-parity / frame-build helpers.
package ps2_host_tx_pkg;

  // Frame geometry: 8 data bits, then parity, then stop; ack on the 11th edge.
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam int ACK_EDGE   = 11;

  // Common keyboard command / response bytes.
  localparam logic [7:0] PS2_BREAK   = 8'hF0;
  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_SET_LED = 8'hED;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_WAIT_IDLE = 3'd4,
    ST_FINISH    = 3'd5
  } tx_state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } tx_err_e;

  // Odd parity: total number of ones over data+parity is odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] b);
    return ~^b;
  endfunction

  // Bits shifted out after the start bit, LSB first: data, parity, stop(1).
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] b);
    return {1'b1, odd_parity(b), b};
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync_negedge.sv
// ps2_sync_negedge
//   Multi-stage synchronizer for one raw PS/2 line plus an optional
//   registered falling-edge pulse. Flops preset to 1 on reset because an
//   idle PS/2 line floats high.
// Ports:
//   clk   - system clock
//   arst  - asynchronous active-high reset
//   din   - raw asynchronous line
//   level - synchronized line level (STAGES cycles of latency)
//   fell  - one-cycle pulse, STAGES+1 cycles after the pad falls (0 when EDGE_EN=0)
module ps2_sync_negedge #(
  parameter int STAGES  = 2,  // must be >= 2
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic arst,
  input  logic din,
  output logic level,
  output logic fell
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;
  logic              fell_r;

  // Synchronizer chain, previous-level register and registered edge pulse.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_r <= '1;
      prev_r <= 1'b1;
      fell_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
      prev_r <= sync_r[STAGES-1];
      fell_r <= prev_r & ~sync_r[STAGES-1];
    end
  end

  assign level = sync_r[STAGES-1];
  assign fell  = EDGE_EN ? fell_r : 1'b0;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter. Inhibits the clock, issues the start
//   bit, shifts data/parity/stop on device-generated falling edges, checks
//   the device ack bit and waits for the bus to go idle. Lines are driven
//   as open-drain enables (1 = pull low).
// Ports:
//   clk           - system clock
//   i_arst        - asynchronous active-high reset
//   i_tx_en       - start strobe, accepted when o_busy=0
//   i_tx_byte     - byte to send, sampled on accept
//   i_ps2_clk     - raw PS/2 clock line
//   i_ps2_data    - raw PS/2 data line
//   o_ps2_clk_oe  - 1 pulls PS/2 clock low
//   o_ps2_data_oe - 1 pulls PS/2 data low
//   o_busy        - transaction in progress
//   o_done        - one-cycle pulse at the end of every transaction
//   o_err         - 00 ok, 01 nack, 10 timeout; valid with o_done, held until next accept
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       i_arst,
  input  logic       i_tx_en,
  input  logic [7:0] i_tx_byte,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  // Cycle before the last inhibit cycle; the start bit is registered here
  // so it is already on the line during the last inhibit cycle.
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic             START_AT_ACCEPT = (INHIBIT_CYCLES == 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       ACK_PREV = 4'(ACK_EDGE - 1);

  tx_state_e             state_r;
  logic [INH_W-1:0]      inh_cnt_r;
  logic [TO_W-1:0]       to_cnt_r;
  logic [3:0]            edge_cnt_r;
  logic [FRAME_BITS-1:0] shift_r;
  logic                  clk_oe_r;
  logic                  data_oe_r;
  logic                  busy_r;
  logic                  done_r;
  logic [1:0]            err_r;

  logic clk_lvl_s;
  logic clk_fe_s;
  logic data_lvl_s;
  logic data_fe_unused_s;
  logic timeout_s;

  ps2_sync_negedge #(
    .STAGES  (SYNC_STAGES),
    .EDGE_EN (1'b1)
  ) u_sync_clk (
    .clk   (clk),
    .arst  (i_arst),
    .din   (i_ps2_clk),
    .level (clk_lvl_s),
    .fell  (clk_fe_s)
  );

  ps2_sync_negedge #(
    .STAGES  (SYNC_STAGES),
    .EDGE_EN (1'b0)
  ) u_sync_data (
    .clk   (clk),
    .arst  (i_arst),
    .din   (i_ps2_data),
    .level (data_lvl_s),
    .fell  (data_fe_unused_s)
  );

  assign timeout_s = (to_cnt_r == TO_LAST);

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or posedge i_arst) begin
    if (i_arst) begin
      state_r    <= ST_IDLE;
      inh_cnt_r  <= '0;
      to_cnt_r   <= '0;
      edge_cnt_r <= 4'd0;
      shift_r    <= '0;
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= ERR_OK;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        // FINISH already shows o_busy=0, so a start strobe there is accepted too.
        ST_IDLE, ST_FINISH: begin
          if (i_tx_en) begin
            shift_r   <= build_frame(i_tx_byte);
            err_r     <= ERR_OK;
            busy_r    <= 1'b1;
            clk_oe_r  <= 1'b1;
            data_oe_r <= START_AT_ACCEPT;
            inh_cnt_r <= '0;
            state_r   <= ST_INHIBIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_INHIBIT: begin
          if (inh_cnt_r == INH_LAST) begin
            clk_oe_r   <= 1'b0;
            to_cnt_r   <= '0;
            edge_cnt_r <= 4'd0;
            state_r    <= ST_REQ;
          end else begin
            inh_cnt_r <= inh_cnt_r + INH_W'(1);
            if (inh_cnt_r == INH_PRE) begin
              data_oe_r <= 1'b1;
            end
          end
        end

        // REQ and SHIFT share edge handling; REQ only differs in that no
        // edge has been seen yet.
        ST_REQ, ST_SHIFT: begin
          if (timeout_s) begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            err_r     <= ERR_TIMEOUT;
            state_r   <= ST_FINISH;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
            if (clk_fe_s) begin
              edge_cnt_r <= edge_cnt_r + 4'd1;
              if (edge_cnt_r == ACK_PREV) begin
                // Device pulls data low on the ack edge.
                if (data_lvl_s == 1'b0) begin
                  state_r <= ST_WAIT_IDLE;
                end else begin
                  clk_oe_r  <= 1'b0;
                  data_oe_r <= 1'b0;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  err_r     <= ERR_NACK;
                  state_r   <= ST_FINISH;
                end
              end else begin
                data_oe_r <= ~shift_r[0];
                shift_r   <= {1'b1, shift_r[FRAME_BITS-1:1]};
                state_r   <= ST_SHIFT;
              end
            end
          end
        end

        ST_WAIT_IDLE: begin
          if (timeout_s) begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            err_r     <= ERR_TIMEOUT;
            state_r   <= ST_FINISH;
          end else if (clk_lvl_s && data_lvl_s) begin
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            err_r     <= ERR_OK;
            state_r   <= ST_FINISH;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end

        default: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ps2_clk_oe  = clk_oe_r;
  assign o_ps2_data_oe = data_oe_r;
  assign o_busy        = busy_r;
  assign o_done        = done_r;
  assign o_err         = err_r;

endmodule
